// File: rtl/accel_pkg.sv
// Shared encodings for the accelerator host bridge: instruction opcodes,
// header field layout and FSM state encoding.
package accel_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  // Header word: opcode in the top OP_W bits, unsigned count in the rest.
  localparam int OP_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout shows the head entry
// whenever empty is low. Simultaneous push and pop are legal at any occupancy.
module sync_fifo #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  pop,
  output logic [W-1:0]          dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_q <= count_q + COUNT_ONE;
      else if (!do_push && do_pop) count_q <= count_q - COUNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/accel_host_bridge.sv
// Host-side bridge: converts framed host packets into cycle-exact accelerator
// instruction/dataIn sequences and streams READ results back via a FIFO.
module accel_host_bridge #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int READ_LAT   = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] dataIn,
  output logic [1:0]   instruction,
  input  logic [W-1:0] dataOut,
  output logic         busy
);

  import accel_pkg::*;

  localparam int CNT_W      = W - OP_W;
  localparam int FIFO_DEPTH = 1 << DEPTH_LOG2;
  // Counts the READ on the instruction register plus the capture pipe,
  // so it can reach READ_LAT+1.
  localparam int IW = $clog2(READ_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]    IF_ONE  = {{(IW - 1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          instr_q;
  logic [W-1:0]        data_in_q;
  logic                s_ready_q;
  logic [READ_LAT-1:0] rd_pipe_q;
  logic [IW-1:0]       inflight_q;

  logic [1:0]          hdr_op;
  logic [CNT_W-1:0]    hdr_cnt;
  logic                accept;
  logic                credit_ok;
  logic                issue;
  logic                push;
  logic                pop;
  logic [W-1:0]        fifo_dout;
  logic                fifo_empty;
  logic                fifo_full;
  logic [DEPTH_LOG2:0] fifo_count;

  assign hdr_op  = s_data[W-1 -: OP_W];
  assign hdr_cnt = s_data[CNT_W-1:0];
  assign accept  = s_valid && s_ready_q;

  // Every READ not yet pushed holds a reserved FIFO slot.
  assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
  assign issue     = (state_q == ST_READ) && credit_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      instr_q   <= OP_NOP;
      data_in_q <= '0;
      s_ready_q <= 1'b0;
    end else begin
      instr_q   <= OP_NOP;
      data_in_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            cnt_q <= hdr_cnt;
            case (hdr_op)
              OP_LOAD: if (hdr_cnt != '0) state_q <= ST_LOAD;
              OP_RUN: begin
                instr_q   <= OP_RUN;
                state_q   <= ST_RUN;
                s_ready_q <= 1'b0;
              end
              OP_READ: if (hdr_cnt != '0) begin
                state_q   <= ST_READ;
                s_ready_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          if (accept) begin
            instr_q   <= OP_LOAD;
            data_in_q <= s_data;
            cnt_q     <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue) begin
            instr_q <= OP_READ;
            cnt_q   <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight_q == '0) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Bit k is set READ_LAT-1-k cycles before dataOut for that READ is valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pipe_q  <= '0;
      inflight_q <= '0;
    end else begin
      rd_pipe_q[0] <= (instr_q == OP_READ);
      for (int i = 1; i < READ_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      if (issue && !push)      inflight_q <= inflight_q + IF_ONE;
      else if (!issue && push) inflight_q <= inflight_q - IF_ONE;
    end
  end

  assign push = rd_pipe_q[READ_LAT-1];
  assign pop  = m_ready && !fifo_empty;

  sync_fifo #(
    .W          (W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_out_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   (dataOut),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assert property (@(posedge CLK) disable iff (RST) !(push && fifo_full && !pop))
    else $error("output FIFO overflow");

  assign s_ready     = s_ready_q;
  assign instruction = instr_q;
  assign dataIn      = data_in_q;
  assign m_valid     = !fifo_empty;
  assign m_data      = fifo_empty ? '0 : fifo_dout;
  assign busy        = (state_q != ST_IDLE) || (inflight_q != '0);

endmodule
